ahb_rr_arbiter: RTL and testbench

//  Parametrised AHB2 bus arbiter for NUM_MASTERS masters. Selects fixed-priority or round-robin mode,

---
 rtl/ahb_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_ahb_rr_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_rr_arbiter.sv
// AHB2 bus arbiter: fixed-priority or round-robin grant with burst beat counting,
// HLOCK handling and forced re-arbitration of long undefined-length INCR bursts.
module ahb_rr_arbiter #(
  parameter  int unsigned NUM_MASTERS    = 4,
  parameter  int unsigned RR_MODE        = 1,
  parameter  int unsigned DEFAULT_MASTER = 0,
  parameter  int unsigned MAX_HOLD       = 16,
  localparam int unsigned ID_W           = $clog2(NUM_MASTERS)
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] m_busreq,
  input  logic [NUM_MASTERS-1:0] m_hlock,
  input  logic [1:0]             s_htrans,
  input  logic [2:0]             s_hburst,
  input  logic                   s_hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [ID_W-1:0]        s_hmaster,
  output logic                   s_hmaster_lock
);

  localparam int unsigned CNT_W = 5;
  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;
  localparam logic [2:0] HB_INCR   = 3'b001;
  localparam logic [CNT_W-1:0]       HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0]        DEF_ID    = ID_W'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GNT   = NUM_MASTERS'(1) << DEFAULT_MASTER;

  typedef enum logic [1:0] {ST_ARB, ST_BURST, ST_UNDEF, ST_LOCKED} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, len_q, len_d, burst_len;
  logic [ID_W-1:0]   gnt_id_q, winner, scan_sel;
  int unsigned       start_idx, scan_idx;
  logic              rearb_ok, owner_lock, is_idle, is_nonseq, is_seq;

  assign owner_lock = m_hlock[gnt_id_q];
  assign is_idle    = (s_htrans == HT_IDLE);
  assign is_nonseq  = (s_htrans == HT_NONSEQ);
  assign is_seq     = (s_htrans == HT_SEQ);

  // Beat count of fixed-length bursts; zero for SINGLE and INCR.
  always_comb begin
    case (s_hburst)
      3'b010, 3'b011: burst_len = CNT_W'(4);
      3'b100, 3'b101: burst_len = CNT_W'(8);
      3'b110, 3'b111: burst_len = CNT_W'(16);
      default:        burst_len = '0;
    endcase
  end

  // Winner scan; the rr pointer always equals the address-phase owner, so s_hmaster serves as it.
  always_comb begin
    start_idx = (RR_MODE != 0) ? 32'(s_hmaster) + 32'd1 : 32'd0;
    scan_idx  = 32'd0;
    scan_sel  = '0;
    winner    = DEF_ID;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      scan_idx = start_idx + 32'(k);
      if (scan_idx >= NUM_MASTERS) scan_idx = scan_idx - NUM_MASTERS;
      scan_sel = ID_W'(scan_idx);
      if (m_busreq[scan_sel]) winner = scan_sel;
    end
  end

  // Next state; a burst's opening NONSEQ keeps the grant so the owner can finish it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    rearb_ok = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (owner_lock) begin
          state_d = ST_LOCKED;
        end else if (is_nonseq && (burst_len != '0)) begin
          state_d = ST_BURST;
          cnt_d   = CNT_W'(1);
          len_d   = burst_len;
        end else if (is_nonseq && (s_hburst == HB_INCR)) begin
          state_d = ST_UNDEF;
          cnt_d   = CNT_W'(1);
        end else begin
          rearb_ok = 1'b1;
        end
      end
      ST_BURST, ST_UNDEF: begin
        if (owner_lock) begin
          state_d = ST_LOCKED;
        end else if (is_idle || is_nonseq) begin
          state_d  = ST_ARB;
          rearb_ok = 1'b1;
        end else if (is_seq) begin
          if (cnt_q == ((state_q == ST_BURST) ? len_q - CNT_W'(1) : HOLD_LAST)) begin
            state_d  = ST_ARB;
            rearb_ok = 1'b1;
          end else begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (!owner_lock && (is_idle || is_nonseq)) begin
          state_d  = ST_ARB;
          rearb_ok = 1'b1;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // All arbitration state advances only on accepted cycles.
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      state_q        <= ST_ARB;
      cnt_q          <= '0;
      len_q          <= '0;
      hgrant         <= DEF_GNT;
      gnt_id_q       <= DEF_ID;
      s_hmaster      <= DEF_ID;
      s_hmaster_lock <= 1'b0;
    end else if (s_hready) begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      len_q          <= len_d;
      s_hmaster      <= gnt_id_q;
      s_hmaster_lock <= owner_lock;
      if (rearb_ok) begin
        gnt_id_q <= winner;
        hgrant   <= NUM_MASTERS'(1) << winner;
      end
    end
  end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Bench for ahb_rr_arbiter: a round-robin and a fixed-priority instance share stimulus
// and are both checked every cycle against a beats-remaining reference model.
module tb_ahb_rr_arbiter;

  localparam int N = 4;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, INCR8 = 3'd5, WRAP16 = 3'd6;
  localparam int P_ARB = 0, P_BURST = 1, P_UNDEF = 2, P_LOCK = 3;

  logic       hclk = 1'b0;
  logic       hreset = 1'b0;
  logic [3:0] m_busreq = '0, m_hlock = '0;
  logic [1:0] s_htrans = IDLE;
  logic [2:0] s_hburst = SINGLE;
  logic       s_hready = 1'b1;
  logic [3:0] hgrant_a, hgrant_b;
  logic [1:0] hmaster_a, hmaster_b;
  logic       lock_a, lock_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state per instance: 0 = round-robin/hold 16, 1 = fixed/hold 4.
  int m_gnt[2], m_own[2], m_lk[2], m_ph[2], m_left[2], m_beats[2];

  ahb_rr_arbiter #(.NUM_MASTERS(4), .RR_MODE(1), .DEFAULT_MASTER(0), .MAX_HOLD(16)) dut_rr (
    .hclk(hclk), .hreset(hreset), .m_busreq(m_busreq), .m_hlock(m_hlock),
    .s_htrans(s_htrans), .s_hburst(s_hburst), .s_hready(s_hready),
    .hgrant(hgrant_a), .s_hmaster(hmaster_a), .s_hmaster_lock(lock_a));

  ahb_rr_arbiter #(.NUM_MASTERS(4), .RR_MODE(0), .DEFAULT_MASTER(0), .MAX_HOLD(4)) dut_fx (
    .hclk(hclk), .hreset(hreset), .m_busreq(m_busreq), .m_hlock(m_hlock),
    .s_htrans(s_htrans), .s_hburst(s_hburst), .s_hready(s_hready),
    .hgrant(hgrant_b), .s_hmaster(hmaster_b), .s_hmaster_lock(lock_b));

  always #5 hclk = ~hclk;

  function automatic int cfg_hold(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  function automatic int fixed_len(input logic [2:0] hb);
    case (hb)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 0;
    endcase
  endfunction

  function automatic int pick(input int i, input int last, input logic [3:0] req);
    int j;
    if (i == 0) begin
      for (int k = 1; k <= N; k++) begin
        j = (last + k) % N;
        if (req[j]) return j;
      end
    end else begin
      for (int m = 0; m < N; m++) if (req[m]) return m;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_gnt[i] = 0; m_own[i] = 0; m_lk[i] = 0; m_ph[i] = P_ARB; m_left[i] = 0; m_beats[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int g, ph, len;
    bit glock, rearb, nonseq, seq, idle_or_ns;
    if (!s_hready) return;
    g          = m_gnt[i];
    ph         = m_ph[i];
    glock      = m_hlock[g];
    rearb      = 1'b0;
    nonseq     = (s_htrans == NSEQ);
    seq        = (s_htrans == SEQ);
    idle_or_ns = (s_htrans == IDLE) || nonseq;
    len        = fixed_len(s_hburst);
    case (ph)
      P_ARB: begin
        if (glock) ph = P_LOCK;
        else if (nonseq && len > 0) begin ph = P_BURST; m_left[i] = len - 1; end
        else if (nonseq && s_hburst == INCR) begin ph = P_UNDEF; m_beats[i] = 1; end
        else rearb = 1'b1;
      end
      P_LOCK: if (!glock && idle_or_ns) begin ph = P_ARB; rearb = 1'b1; end
      default: begin
        if (glock) ph = P_LOCK;
        else if (idle_or_ns) begin ph = P_ARB; rearb = 1'b1; end
        else if (seq && ph == P_BURST) begin
          if (m_left[i] == 1) begin ph = P_ARB; rearb = 1'b1; end
          else m_left[i]--;
        end else if (seq) begin
          if (m_beats[i] + 1 == cfg_hold(i)) begin ph = P_ARB; rearb = 1'b1; end
          else m_beats[i]++;
        end
      end
    endcase
    m_ph[i] = ph;
    m_lk[i] = int'(glock);
    if (rearb) m_gnt[i] = pick(i, m_own[i], m_busreq);
    m_own[i] = g;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("rr_gnt",    32'(hgrant_a), 32'(1) << m_gnt[0]);
    chk("rr_own",    32'(hmaster_a), m_own[0]);
    chk("rr_lock",   32'(lock_a), m_lk[0]);
    chk("rr_onehot", 32'($onehot(hgrant_a)), 32'd1);
    chk("fx_gnt",    32'(hgrant_b), 32'(1) << m_gnt[1]);
    chk("fx_own",    32'(hmaster_b), m_own[1]);
    chk("fx_lock",   32'(lock_b), m_lk[1]);
    chk("fx_onehot", 32'($onehot(hgrant_b)), 32'd1);
  endtask

  // One bus cycle: drive, advance the model, take the edge, compare.
  task automatic cyc(input logic [3:0] req, input logic [3:0] lk, input logic [1:0] tr,
                     input logic [2:0] hb, input logic rdy);
    m_busreq = req; m_hlock = lk; s_htrans = tr; s_hburst = hb; s_hready = rdy;
    if (!hreset) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
    @(posedge hclk);
    #1;
    check_all();
  endtask

  initial begin
    logic [3:0] r_req, r_lk;
    model_reset();

    // reset held with random requests
    repeat (3) cyc(4'($urandom), 4'($urandom), 2'($urandom), 3'($urandom), 1'b1);
    chk("rst_gnt", 32'(hgrant_a), 32'h1);
    chk("rst_own", 32'(hmaster_a), 32'h0);
    chk("rst_lock", 32'(lock_a), 32'h0);
    hreset = 1'b1;

    // round-robin fairness with SINGLE transfers
    for (int c = 1; c <= 8; c++) begin
      cyc(4'b1111, 4'b0000, NSEQ, SINGLE, 1'b1);
      if (c % 2 == 0) chk("s2_rr_own", 32'(hmaster_a), 32'((c / 2) % 4));
      chk("s2_fx_own", 32'(hmaster_b), 32'h0);
    end

    // INCR8 from M2 with M0 waiting, one wait state and one BUSY
    repeat (2) cyc(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1);
    chk("s3_setup_own", 32'(hmaster_a), 32'h2);
    cyc(4'b0101, 4'b0000, NSEQ, INCR8, 1'b1);
    chk("s3_beat1_gnt", 32'(hgrant_a), 32'h4);
    cyc(4'b0101, 4'b0000, SEQ, INCR8, 1'b0);
    cyc(4'b0101, 4'b0000, SEQ, INCR8, 1'b1);
    cyc(4'b0101, 4'b0000, BUSY, INCR8, 1'b1);
    for (int b = 3; b <= 7; b++) cyc(4'b0101, 4'b0000, SEQ, INCR8, 1'b1);
    chk("s3_beat7_gnt", 32'(hgrant_a), 32'h4);
    cyc(4'b0101, 4'b0000, SEQ, INCR8, 1'b1);
    chk("s3_beat8_gnt", 32'(hgrant_a), 32'h1);
    chk("s3_beat8_fx", 32'(hgrant_b), 32'h1);
    chk("s3_beat8_own", 32'(hmaster_a), 32'h2);
    cyc(4'b0101, 4'b0000, IDLE, SINGLE, 1'b1);
    chk("s3_m0_owns", 32'(hmaster_a), 32'h0);

    // INCR from M1 forced off after MAX_HOLD beats on the hold-4 instance
    repeat (2) cyc(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1);
    chk("s4_setup_own", 32'(hmaster_b), 32'h1);
    cyc(4'b1000, 4'b0000, NSEQ, INCR, 1'b1);
    repeat (2) cyc(4'b1000, 4'b0000, SEQ, INCR, 1'b1);
    chk("s4_beat3_fx", 32'(hgrant_b), 32'h2);
    cyc(4'b1000, 4'b0000, SEQ, INCR, 1'b1);
    chk("s4_beat4_fx", 32'(hgrant_b), 32'h8);
    chk("s4_beat4_rr", 32'(hgrant_a), 32'h2);
    cyc(4'b1000, 4'b0000, SEQ, INCR, 1'b1);
    chk("s4_beat5_rr", 32'(hgrant_a), 32'h2);
    repeat (2) cyc(4'b1000, 4'b0000, IDLE, SINGLE, 1'b1);
    chk("s4_m3_owns", 32'(hmaster_a), 32'h3);

    // locked transfers from M3 with M0 waiting
    for (int t = 0; t < 3; t++) begin
      cyc(4'b1001, 4'b1000, NSEQ, SINGLE, 1'b1);
      chk("s5_lock_gnt", 32'(hgrant_a), 32'h8);
      chk("s5_lock_flag", 32'(lock_a), 32'h1);
    end
    cyc(4'b1001, 4'b0000, SEQ, SINGLE, 1'b1);
    chk("s5_drop_gnt", 32'(hgrant_a), 32'h8);
    chk("s5_drop_flag", 32'(lock_a), 32'h0);
    cyc(4'b1001, 4'b0000, IDLE, SINGLE, 1'b1);
    chk("s5_m0_gnt", 32'(hgrant_a), 32'h1);
    cyc(4'b1001, 4'b0000, IDLE, SINGLE, 1'b1);
    chk("s5_m0_own", 32'(hmaster_a), 32'h0);

    // async reset in the middle of a WRAP16
    repeat (2) cyc(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1);
    cyc(4'b0100, 4'b0000, NSEQ, WRAP16, 1'b1);
    repeat (5) cyc(4'b0100, 4'b0000, SEQ, WRAP16, 1'b1);
    s_htrans = SEQ;
    #2 hreset = 1'b0;
    #1;
    model_reset();
    chk("s6_async_gnt", 32'(hgrant_a), 32'h1);
    chk("s6_async_own", 32'(hmaster_a), 32'h0);
    check_all();
    repeat (2) cyc(4'($urandom), 4'($urandom), 2'($urandom), 3'($urandom), 1'b1);
    hreset = 1'b1;
    cyc(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1);
    chk("s6_m1_gnt", 32'(hgrant_a), 32'h2);
    chk("s6_m1_gnt_fx", 32'(hgrant_b), 32'h2);

    // randomized traffic with occasional lock and reset pulses
    repeat (400) begin
      r_req  = 4'($urandom);
      r_lk   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      hreset = ($urandom_range(0, 99) != 0);
      cyc(r_req, r_lk, 2'($urandom), 3'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
